// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator: scans a/b MSB-first, CHUNK bits per
// cycle, and reports a one-hot g/e/l result through a valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (accepted only in IDLE)
//   a, b                 WIDTH-bit unsigned operands
//   out_valid/out_ready  result handshake; result held until out_ready
//   g, e, l              a>b, a==b, a<b (registered, one-hot when out_valid)
//   busy                 high while slices are being compared
module seq_magnitude_comparator #(
    parameter int WIDTH      = 256,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             g,
    output logic             e,
    output logic             l,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WIDTH-1:0]  sh_a;
    logic [WIDTH-1:0]  sh_b;
    logic [CW-1:0]     cnt;
    logic [CHUNK-1:0]  top_a;
    logic [CHUNK-1:0]  top_b;
    logic              slice_gt;
    logic              slice_lt;
    logic              last;
    logic              decided;

    assign top_a    = sh_a[WIDTH-1 -: CHUNK];
    assign top_b    = sh_b[WIDTH-1 -: CHUNK];
    assign slice_gt = top_a > top_b;
    assign slice_lt = top_a < top_b;
    assign last     = (cnt == CW'(NCHUNK - 1));
    // g/l are cleared on operand accept, so either being set means an
    // earlier (more significant) slice already decided the result.
    assign decided  = g | l;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == COMPARE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (in_valid) state_n = COMPARE;
            end
            COMPARE: begin
                if (last || ((EARLY_EXIT != 0) && (slice_gt || slice_lt)))
                    state_n = DONE;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            g     <= 1'b0;
            e     <= 1'b0;
            l     <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a <= a;
                        sh_b <= b;
                        cnt  <= '0;
                        g    <= 1'b0;
                        e    <= 1'b0;
                        l    <= 1'b0;
                    end
                end
                COMPARE: begin
                    sh_a <= sh_a << CHUNK;
                    sh_b <= sh_b << CHUNK;
                    if (!last) cnt <= cnt + 1'b1;
                    if (!decided) begin
                        g <= slice_gt;
                        l <= slice_lt;
                        if (last && !slice_gt && !slice_lt) e <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator: five instances cover
// early/full scan, a single-slice build and the 256-bit target case.
module tb_seq_magnitude_comparator;

    localparam int N = 5;

    logic         clk;
    logic         rst_n;
    logic [255:0] av [N];
    logic [255:0] bv [N];
    logic         iv [N];
    logic         ordy [N];
    logic         ir [N];
    logic         ov [N];
    logic         gq [N];
    logic         eq [N];
    logic         lq [N];
    logic         bz [N];

    int vectors;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][15:0]), .b(bv[0][15:0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .g(gq[0]), .e(eq[0]), .l(lq[0]), .busy(bz[0]));

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1][15:0]), .b(bv[1][15:0]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .g(gq[1]), .e(eq[1]), .l(lq[1]), .busy(bz[1]));

    seq_magnitude_comparator #(.WIDTH(256), .CHUNK(8), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2]), .b(bv[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .g(gq[2]), .e(eq[2]), .l(lq[2]), .busy(bz[2]));

    seq_magnitude_comparator #(.WIDTH(256), .CHUNK(8), .EARLY_EXIT(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(av[3]), .b(bv[3]), .out_valid(ov[3]),
        .out_ready(ordy[3]), .g(gq[3]), .e(eq[3]), .l(lq[3]), .busy(bz[3]));

    seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
        .a(av[4][7:0]), .b(bv[4][7:0]), .out_valid(ov[4]),
        .out_ready(ordy[4]), .g(gq[4]), .e(eq[4]), .l(lq[4]), .busy(bz[4]));

    function automatic int wid(input int i);
        case (i)
            0, 1:    return 16;
            2, 3:    return 256;
            default: return 8;
        endcase
    endfunction

    function automatic int chk(input int i);
        case (i)
            0, 1:    return 4;
            2, 3:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic bit early(input int i);
        return (i != 1) && (i != 3);
    endfunction

    function automatic logic [255:0] mask(input int i);
        logic [255:0] m;
        m = '1;
        if (wid(i) < 256) m = (256'd1 << wid(i)) - 256'd1;
        return m;
    endfunction

    // Reference: result from plain arithmetic; latency from the position of
    // the most significant differing bit.
    function automatic int ref_lat(input int i, input logic [255:0] x,
                                   input logic [255:0] y);
        logic [255:0] d;
        int           p;
        d = x ^ y;
        p = -1;
        for (int k = 255; k >= 0; k--) begin
            if (d[k] && p < 0) p = k;
        end
        if (!early(i) || p < 0) return wid(i) / chk(i);
        return (wid(i) - 1 - p) / chk(i) + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for the result and check result/latency.
    // Leaves the DUT in DONE when hold is set, else accepts the result.
    task automatic run(input int i, input logic [255:0] x0,
                       input logic [255:0] y0, input bit hold);
        logic [255:0] x;
        logic [255:0] y;
        int           lat;
        int           cnt;
        x = x0 & mask(i);
        y = y0 & mask(i);
        lat = ref_lat(i, x, y);
        check($sformatf("in_ready_u%0d", i), 32'(ir[i]), 32'd1);
        av[i] = x;
        bv[i] = y;
        iv[i] = 1'b1;
        tick();
        iv[i] = 1'b0;
        av[i] = '1;
        bv[i] = '0;
        cnt = 0;
        while (!ov[i] && cnt <= lat + 3) begin
            tick();
            cnt++;
        end
        check($sformatf("out_valid_u%0d", i), 32'(ov[i]), 32'd1);
        check($sformatf("latency_u%0d", i), 32'(cnt), 32'(lat));
        check($sformatf("gel_u%0d", i), {29'd0, gq[i], eq[i], lq[i]},
              {29'd0, x > y, x == y, x < y});
        if (!hold) begin
            ordy[i] = 1'b1;
            tick();
            ordy[i] = 1'b0;
            check($sformatf("idle_u%0d", i), {30'd0, ov[i], ir[i]}, 32'd1);
        end
    endtask

    initial begin
        logic [255:0] x;
        logic [255:0] y;
        int           s;
        vectors = 0;
        errors  = 0;
        for (int i = 0; i < N; i++) begin
            av[i] = '0; bv[i] = '0; iv[i] = 1'b0; ordy[i] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_state", {26'd0, ov[0], gq[0], eq[0], lq[0], bz[0], ir[0]},
              32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a full-scan compare.
        av[1] = 256'hA000; bv[1] = 256'h9FFF; iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        tick();
        check("busy_mid", 32'(bz[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid", {27'd0, ov[1], gq[1], eq[1], lq[1], bz[1]}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rdy_after_rst", 32'(ir[1]), 32'd1);

        run(0, 256'hA000, 256'h9FFF, 1'b0);
        run(1, 256'hA000, 256'h9FFF, 1'b0);
        run(0, 256'h1234, 256'h1235, 1'b0);
        run(0, 256'hBEEF, 256'hBEEF, 1'b0);
        run(1, 256'h0F00, 256'h1000, 1'b0);
        run(1, 256'h0000, 256'h0000, 1'b0);
        run(0, 256'hFFFF, 256'hFFFF, 1'b0);
        run(4, 256'h7F, 256'h80, 1'b0);
        run(4, 256'h5A, 256'h5A, 1'b0);

        // Backpressure: result held, new operands ignored.
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check("early_ordy", {30'd0, ov[0], ir[0]}, 32'd1);
        run(0, 256'hA000, 256'h9FFF, 1'b1);
        av[0] = 256'h0001; bv[0] = 256'hFFFF; iv[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold", {28'd0, ov[0], gq[0], lq[0], ir[0]}, 32'b1100);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check("bp_release", {30'd0, ov[0], ir[0]}, 32'd1);
        check("bp_kept", {29'd0, gq[0], eq[0], lq[0]}, 32'b100);

        // Wide operands: random, shared-prefix, equal and target-style pairs.
        for (int t = 0; t < 1000; t++) begin
            for (int w = 0; w < 8; w++) begin
                x[w*32 +: 32] = $urandom;
                y[w*32 +: 32] = $urandom;
            end
            s = int'($urandom_range(0, 4));
            if (s == 1) begin
                y = x;
                y[$urandom_range(0, 255)] ^= 1'b1;
            end else if (s == 2) begin
                y = x;
            end else if (s == 3) begin
                y = y >> $urandom_range(8, 64);
            end
            run(2, x, y, 1'b0);
            if (t % 10 == 0) run(3, x, y, 1'b0);
        end
        run(2, '0, '0, 1'b0);
        run(2, '1, '1, 1'b0);
        run(3, '1, '1, 1'b0);
        run(2, 256'h0000_0000_0000_0001 << 200, '1 >> 56, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
